if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised successor to the fixed 3-stage IF pipeline.
- Combines the PC generator, the inst SRAM request issue with a fixed read latency of SRAM_LAT, and a DEPTH-entry instruction queue feeding decode.
- Decode handshake is valid/ready; the old 6-bit stall vector is gone.
- Flush/branch redirect drops all queued entries and all in-flight SRAM responses.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
DEPTH, 8, queue entries (power of 2, >=2)
SRAM_LAT, 2, cycles from inst_sram_en to valid inst_sram_rdata (>=1)
FS_TO_DS_BUS_WD, 65, {excp_adef, pc, inst}

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  exception/ertn redirect, highest priority
new_pc  in  32  flush target
br_taken  in  1  branch redirect from decode/execute
br_target  in  32  branch target
inst_sram_en  out  1  read request this cycle
inst_sram_addr  out  32  request address (fetch PC)
inst_sram_rdata  in  32  read data, valid SRAM_LAT cycles after request
ds_valid  out  1  queue head valid
ds_ready  in  1  decode accepts head
fs_to_ds_bus  out  FS_TO_DS_BUS_WD  queue head {excp_adef[64], pc[63:32], inst[31:0]}

Behaviour:
- Reset (reset==0, async) clears all state:
  - pc=RESET_PC, queue empty, in-flight pipe cleared, halted=0.
  - Outputs: inst_sram_en=0, ds_valid=0, fs_to_ds_bus=0.
- First request is issued in the first clk edge cycle after reset deasserts.
- Credits: a request may issue only when count + inflight < DEPTH.
  - count = queue occupancy; inflight = number of valid slots in the SRAM_LAT-deep tag pipe.
  - This guarantees no response is ever dropped for lack of space.
- Issue, in a cycle with no flush/br_taken, credit available, halted=0:
  - If pc[1:0]==0: inst_sram_en=1, addr=pc, tag {1,pc,adef=0} enters pipe slot 0, pc<=pc+4.
  - If pc[1:0]!=0: no SRAM request; entry {adef=1, pc, inst=0} goes through the tag pipe with the same latency; halted<=1.
- halted suppresses further issue until the next flush or br_taken.
- Tag pipe: shifts every cycle. At slot SRAM_LAT-1 with valid=1, {adef, pc, adef?0:inst_sram_rdata} is enqueued that cycle.
- Queue:
  - Circular buffer, log2(DEPTH)+1-bit pointers.
  - Enqueue and dequeue in the same cycle are both legal, including when full (dequeue frees the slot).
  - Dequeue when ds_valid && ds_ready.
  - fs_to_ds_bus = head entry when ds_valid, else 0.
- Redirect (flush | br_taken) in cycle T:
  - inst_sram_en=0 in T.
  - Queue is emptied and all tag-pipe valid bits are cleared at the edge ending T; responses returning after T are discarded.
  - No dequeue occurs in T: ds_valid is forced 0 in T.
  - pc <= flush ? new_pc : br_target; halted<=0.
  - A request from the new pc may issue in T+1.
- flush and br_taken together: flush wins, new_pc is used.
- Back-to-back redirects: each cycle's redirect wins; only the last target is fetched.
- Steady state with ds_ready=1: one instruction per cycle; first ds_valid occurs SRAM_LAT cycles after the first request.

Optional Feature:
IFQ_PERF_CNT_EN
- Defined:
  - Adds output perf_stall_cnt[31:0]: counts cycles where halted==0, no redirect, and credit is exhausted.
  - Adds output perf_drop_cnt[31:0]: on a redirect, adds the number of entries discarded (queue count + inflight).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, ds_ready=1, SRAM_LAT=2: requests at 1c000000, 1c000004, ...; ds_valid first high 2 cycles after the first request with pc=1c000000; one instruction per cycle thereafter.
- ds_ready=0 held: exactly DEPTH=8 requests issue, then inst_sram_en stays 0; queue holds 8 entries. Set ds_ready=1 for 1 cycle: one dequeue, then one new request issues.
- br_taken with target 1c000100 while queue holds 5 entries and 2 are in flight:
  - Next cycle ds_valid=0 and the first request is to 1c000100.
  - The two stale rdata returns are never seen at decode.
- flush (new_pc=1c008000) and br_taken (1c000200) in the same cycle: fetch resumes at 1c008000 only.
- br_target=1c000102:
  - No SRAM request is made.
  - After 2 cycles, head = {adef=1, pc=1c000102, inst=0}.
  - No further requests until a flush to 1c008000, which resumes fetch there.
- Async reset asserted mid-stream while the queue is full: ds_valid and inst_sram_en drop to 0 immediately without a clock edge; after release, fetch restarts at RESET_PC. With IFQ_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - PC generator, fixed-latency inst SRAM issue and decode instruction queue.
// Optional IFQ_PERF_CNT_EN adds stall/drop performance counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          DEPTH           = 8,
  parameter int          SRAM_LAT        = 2,
  parameter int          FS_TO_DS_BUS_WD = 65
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                new_pc,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       inst_sram_en,
  output logic [31:0]                inst_sram_addr,
  input  logic [31:0]                inst_sram_rdata,
  output logic                       ds_valid,
  input  logic                       ds_ready,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + SRAM_LAT + 1);

  logic [31:0]                pc_q, pc_d;
  logic                       halted_q, halted_d;
  logic [SRAM_LAT-1:0]        tv_q;
  logic [SRAM_LAT-1:0]        tadef_q;
  logic [SRAM_LAT-1:0][31:0]  tpc_q;
  logic [PW-1:0]              wr_q, wr_d, rd_q, rd_d;
  logic [FS_TO_DS_BUS_WD-1:0] mem_q [DEPTH];

  logic                       redirect, credit, issue, aligned;
  logic [PW-1:0]              count;
  logic [CW-1:0]              inflight, occupied;
  logic                       resp_v, empty, deq, enq_mem;
  logic [FS_TO_DS_BUS_WD-1:0] resp_entry, head;

  assign redirect = flush | br_taken;
  assign count    = wr_q - rd_q;
  assign empty    = (wr_q == rd_q);
  assign aligned  = (pc_q[1:0] == 2'b00);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LAT; i++) begin
      inflight = inflight + CW'(tv_q[i]);
    end
  end

  // Reserving a slot per in-flight tag means a returning response always has room.
  assign occupied = CW'(count) + inflight;
  assign credit   = occupied < CW'(DEPTH);
  assign issue    = !redirect && credit && !halted_q;

  assign inst_sram_en   = issue && aligned && reset;
  assign inst_sram_addr = pc_q;

  assign resp_v     = tv_q[SRAM_LAT-1] && !redirect;
  assign resp_entry = {tadef_q[SRAM_LAT-1], tpc_q[SRAM_LAT-1],
                       tadef_q[SRAM_LAT-1] ? 32'h0 : inst_sram_rdata};

  // An empty queue presents the arriving response directly so decode sees it that cycle.
  assign head         = empty ? resp_entry : mem_q[rd_q[AW-1:0]];
  assign ds_valid     = !redirect && (!empty || resp_v);
  assign fs_to_ds_bus = ds_valid ? head : '0;
  assign deq          = ds_valid && ds_ready;
  assign enq_mem      = resp_v && !(empty && deq);

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    wr_d     = wr_q + PW'(enq_mem);
    rd_d     = rd_q + PW'(deq && !empty);
    if (redirect) begin
      pc_d     = flush ? new_pc : br_target;
      halted_d = 1'b0;
      wr_d     = '0;
      rd_d     = '0;
    end else if (issue) begin
      if (aligned) pc_d = pc_q + 32'd4;
      else         halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      tv_q     <= '0;
      tadef_q  <= '0;
      tpc_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      for (int i = SRAM_LAT - 1; i > 0; i--) begin
        tv_q[i]    <= redirect ? 1'b0 : tv_q[i-1];
        tadef_q[i] <= tadef_q[i-1];
        tpc_q[i]   <= tpc_q[i-1];
      end
      tv_q[0]    <= issue;
      tadef_q[0] <= !aligned;
      tpc_q[0]   <= pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_mem) mem_q[wr_q[AW-1:0]] <= resp_entry;
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_q, drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (!halted_q && !redirect && !credit) stall_q <= stall_q + 32'd1;
      if (redirect) drop_q <= drop_q + 32'(occupied);
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_drop_cnt  = drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed self-checking bench for if_fetch_queue.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, flush, br_taken, ds_ready;
  logic [31:0] new_pc, br_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic        ds_valid;
  logic [64:0] fs_to_ds_bus;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_en;
  logic [31:0] last_addr;

  if_fetch_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_target(br_target),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_valid(ds_valid), .ds_ready(ds_ready), .fs_to_ds_bus(fs_to_ds_bus)
`ifdef IFQ_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Two-cycle SRAM: address captured in cycle T returns its word in cycle T+2.
  logic [31:0] a1 = 32'h0, a2 = 32'h0;
  always @(posedge clk) begin
    a1 <= inst_sram_addr;
    a2 <= a1;
  end
  assign inst_sram_rdata = a2 ^ 32'hFFFF_0000;

  function automatic logic [64:0] ent(input logic [31:0] pc);
    return {1'b0, pc, pc ^ 32'hFFFF_0000};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; br_taken = 1'b0; ds_ready = 1'b1;
    new_pc = 32'h0; br_target = 32'h0;
    #1;
    check("rst_en", 65'(inst_sram_en), 65'd0);
    check("rst_dsv", 65'(ds_valid), 65'd0);
    check("rst_bus", fs_to_ds_bus, 65'd0);
    cyc(); cyc();

    // Reset release and streaming
    reset = 1'b1; #1;
    check("c0_en", 65'(inst_sram_en), 65'd1);
    check("c0_addr", 65'(inst_sram_addr), 65'h1c000000);
    check("c0_dsv", 65'(ds_valid), 65'd0);
    cyc();
    check("c1_addr", 65'(inst_sram_addr), 65'h1c000004);
    check("c1_dsv", 65'(ds_valid), 65'd0);
    cyc();
    check("c2_dsv", 65'(ds_valid), 65'd1);
    check("c2_bus", fs_to_ds_bus, ent(32'h1c000000));
    check("c2_addr", 65'(inst_sram_addr), 65'h1c000008);
    cyc();
    check("c3_bus", fs_to_ds_bus, ent(32'h1c000004));
    cyc();
    check("c4_bus", fs_to_ds_bus, ent(32'h1c000008));

    // Credit limit with decode stalled
    flush = 1'b1; new_pc = 32'h1c001000; ds_ready = 1'b0; #1;
    check("fl_en", 65'(inst_sram_en), 65'd0);
    check("fl_dsv", 65'(ds_valid), 65'd0);
    cyc();
    flush = 1'b0; #1;
    n_en = 0; last_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (inst_sram_en) begin
        n_en++;
        last_addr = inst_sram_addr;
      end
      cyc();
    end
    check("full_nreq", 65'(n_en), 65'd8);
    check("full_last", 65'(last_addr), 65'h1c00101c);
    check("full_en", 65'(inst_sram_en), 65'd0);
    ds_ready = 1'b1; #1;
    check("full_head", fs_to_ds_bus, ent(32'h1c001000));
    check("full_deq_en", 65'(inst_sram_en), 65'd0);
    cyc();
    ds_ready = 1'b0; #1;
    check("refill_en", 65'(inst_sram_en), 65'd1);
    check("refill_addr", 65'(inst_sram_addr), 65'h1c001020);
    check("refill_head", fs_to_ds_bus, ent(32'h1c001004));
    cyc();
    check("refill_stop", 65'(inst_sram_en), 65'd0);

    // Branch with 5 queued and 2 in flight
    flush = 1'b1; new_pc = 32'h1c002000; #1;
    cyc();
    flush = 1'b0; #1;
    for (int i = 0; i < 7; i++) cyc();
    check("pre_br_addr", 65'(inst_sram_addr), 65'h1c00201c);
    br_taken = 1'b1; br_target = 32'h1c000100; #1;
    check("br_en", 65'(inst_sram_en), 65'd0);
    check("br_dsv", 65'(ds_valid), 65'd0);
    cyc();
    br_taken = 1'b0; ds_ready = 1'b1; #1;
    check("br1_dsv", 65'(ds_valid), 65'd0);
    check("br1_addr", 65'(inst_sram_addr), 65'h1c000100);
    check("br1_en", 65'(inst_sram_en), 65'd1);
    cyc();
    check("br2_dsv", 65'(ds_valid), 65'd0);
    cyc();
    check("br3_bus", fs_to_ds_bus, ent(32'h1c000100));
    cyc();
    check("br4_bus", fs_to_ds_bus, ent(32'h1c000104));

    // Flush beats branch
    flush = 1'b1; new_pc = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000200; #1;
    check("fb_en", 65'(inst_sram_en), 65'd0);
    cyc();
    flush = 1'b0; br_taken = 1'b0; #1;
    check("fb_addr", 65'(inst_sram_addr), 65'h1c008000);
    check("fb_dsv", 65'(ds_valid), 65'd0);
    cyc(); cyc();
    check("fb_bus", fs_to_ds_bus, ent(32'h1c008000));

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h1c000102; #1;
    cyc();
    br_taken = 1'b0; #1;
    check("adef1_en", 65'(inst_sram_en), 65'd0);
    check("adef1_dsv", 65'(ds_valid), 65'd0);
    cyc();
    check("adef2_dsv", 65'(ds_valid), 65'd0);
    cyc();
    check("adef_bus", fs_to_ds_bus, {1'b1, 32'h1c000102, 32'h0});
    cyc();
    check("adef_after_dsv", 65'(ds_valid), 65'd0);
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      if (inst_sram_en) n_en++;
      cyc();
    end
    check("adef_halt", 65'(n_en), 65'd0);
    flush = 1'b1; new_pc = 32'h1c008000; #1;
    cyc();
    flush = 1'b0; #1;
    check("adef_resume_en", 65'(inst_sram_en), 65'd1);
    check("adef_resume_addr", 65'(inst_sram_addr), 65'h1c008000);

    // Async reset while full
    ds_ready = 1'b0; #1;
    for (int i = 0; i < 12; i++) cyc();
    check("ar_full_dsv", 65'(ds_valid), 65'd1);
    check("ar_full_en", 65'(inst_sram_en), 65'd0);
    #2;
    reset = 1'b0; #1;
    check("ar_dsv", 65'(ds_valid), 65'd0);
    check("ar_en", 65'(inst_sram_en), 65'd0);
    check("ar_bus", fs_to_ds_bus, 65'd0);
`ifdef IFQ_PERF_CNT_EN
    check("ar_stall", 65'(perf_stall_cnt), 65'd0);
    check("ar_drop", 65'(perf_drop_cnt), 65'd0);
`endif
    cyc(); cyc();
    reset = 1'b1; #1;
    check("ar_rel_en", 65'(inst_sram_en), 65'd1);
    check("ar_rel_addr", 65'(inst_sram_addr), 65'h1c000000);
    check("ar_rel_dsv", 65'(ds_valid), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
